// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: pipeline request/response handshakes
// and the single-cycle data cache port.

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault
  );
endinterface

interface dcache_if #(parameter int ADDR_BITS = 6);
  logic                 cache_mode;
  logic [2:0]           cache_width;
  logic [ADDR_BITS-1:0] cache_select;
  logic [31:0]          cache_in;
  logic [31:0]          cache_out;

  modport master (
    output cache_mode, cache_width, cache_select, cache_in,
    input  cache_out
  );

  modport slave (
    input  cache_mode, cache_width, cache_select, cache_in,
    output cache_out
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, one cache cycle per legal request.
// Optional fault detection is enabled by defining LSU_FAULT_CHECK_EN.

module load_store_unit #(
  parameter int ADDR_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  pipe,
  dcache_if.master          cache
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic                 accept_s;
  logic                 resp_done_s;
  logic                 fault_s;
  logic                 write_r;
  logic                 req_ready_r;
  logic                 resp_valid_r;
  logic                 resp_fault_r;
  logic [31:0]          resp_data_r;
  logic [4:0]           resp_rd_r;
  logic                 cache_mode_r;
  logic [2:0]           cache_width_r;
  logic [ADDR_BITS-1:0] cache_select_r;
  logic [31:0]          cache_in_r;

`ifdef LSU_FAULT_CHECK_EN
  function automatic logic check_fault(input logic write, input logic [2:0] funct3,
                                       input logic [31:0] addr);
    logic range_bad_s;
    logic align_bad_s;
    logic code_bad_s;
    range_bad_s = ((addr >> ADDR_BITS) != 32'd0);
    case (funct3)
      3'b000: begin align_bad_s = 1'b0;              code_bad_s = 1'b0;  end
      3'b001: begin align_bad_s = addr[0];           code_bad_s = 1'b0;  end
      3'b010: begin align_bad_s = (addr[1:0] != 2'b00); code_bad_s = 1'b0; end
      3'b100: begin align_bad_s = 1'b0;              code_bad_s = write; end
      3'b101: begin align_bad_s = addr[0];           code_bad_s = write; end
      default: begin align_bad_s = 1'b0;             code_bad_s = 1'b1;  end
    endcase
    return range_bad_s | align_bad_s | code_bad_s;
  endfunction

  assign fault_s = check_fault(pipe.req_write, pipe.req_funct3, pipe.req_addr);
`else
  // Upper address bits are simply dropped when no checking is built in.
  logic unused_addr_s;
  assign unused_addr_s = ^pipe.req_addr[31:ADDR_BITS];
  assign fault_s       = 1'b0;
`endif

  assign accept_s    = (state_r == IDLE) && pipe.req_valid;
  assign resp_done_s = (state_r == RESP) && resp_valid_r && pipe.resp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pipe.req_valid) begin
          next_state_s = fault_s ? RESP : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE:   next_state_s = CAPTURE;
      CAPTURE: next_state_s = RESP;
      RESP: begin
        if (resp_done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Request-side bookkeeping: ready drops on acceptance and returns on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      write_r     <= 1'b0;
    end else if (accept_s) begin
      req_ready_r <= 1'b0;
      write_r     <= pipe.req_write;
    end else if (resp_done_s) begin
      req_ready_r <= 1'b1;
    end
  end

  // Cache port: carries the request only while in ISSUE, otherwise parked as an idle read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_mode_r   <= 1'b1;
      cache_width_r  <= 3'b010;
      cache_select_r <= {ADDR_BITS{1'b0}};
      cache_in_r     <= 32'd0;
    end else if (accept_s && !fault_s) begin
      cache_mode_r   <= ~pipe.req_write;
      cache_width_r  <= pipe.req_funct3;
      cache_select_r <= pipe.req_addr[ADDR_BITS-1:0];
      cache_in_r     <= pipe.req_wdata;
    end else begin
      cache_mode_r   <= 1'b1;
      cache_width_r  <= 3'b010;
      cache_select_r <= {ADDR_BITS{1'b0}};
      cache_in_r     <= 32'd0;
    end
  end

  // Response payload and valid; valid rises one cycle after RESP is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_rd_r    <= 5'd0;
    end else if (accept_s) begin
      resp_fault_r <= fault_s;
      resp_data_r  <= 32'd0;
      resp_rd_r    <= pipe.req_rd;
    end else if (state_r == CAPTURE) begin
      resp_data_r  <= write_r ? 32'd0 : cache.cache_out;
    end else if ((state_r == RESP) && !resp_valid_r) begin
      resp_valid_r <= 1'b1;
    end else if (resp_done_s) begin
      resp_valid_r <= 1'b0;
    end
  end

  assign pipe.req_ready    = req_ready_r;
  assign pipe.resp_valid   = resp_valid_r;
  assign pipe.resp_fault   = resp_fault_r;
  assign pipe.resp_data    = resp_data_r;
  assign pipe.resp_rd      = resp_rd_r;
  assign cache.cache_mode   = cache_mode_r;
  assign cache.cache_width  = cache_width_r;
  assign cache.cache_select = cache_select_r;
  assign cache.cache_in     = cache_in_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed behavioural data cache.

module tb_load_store_unit;

`ifdef LSU_FAULT_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  load_store_unit_if pif();
  dcache_if #(.ADDR_BITS(6)) cif();

  load_store_unit #(.ADDR_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pif.slave),
    .cache (cif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cache: little-endian bytes, sign/zero extension by funct3, one-cycle read.
  logic [7:0] mem [0:63];
  bit mem_ready = 1'b0;

  function automatic logic [31:0] cache_read(input logic [5:0] a, input logic [2:0] w);
    logic [31:0] word;
    word = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    case (w)
      3'b000:  return {{24{word[7]}}, word[7:0]};
      3'b001:  return {{16{word[15]}}, word[15:0]};
      3'b100:  return {24'd0, word[7:0]};
      3'b101:  return {16'd0, word[15:0]};
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (cif.cache_mode === 1'b0) begin
        case (cif.cache_width[1:0])
          2'b00: mem[cif.cache_select] <= cif.cache_in[7:0];
          2'b01: begin
            mem[cif.cache_select]         <= cif.cache_in[7:0];
            mem[cif.cache_select + 6'd1]  <= cif.cache_in[15:8];
          end
          default: begin
            mem[cif.cache_select]         <= cif.cache_in[7:0];
            mem[cif.cache_select + 6'd1]  <= cif.cache_in[15:8];
            mem[cif.cache_select + 6'd2]  <= cif.cache_in[23:16];
            mem[cif.cache_select + 6'd3]  <= cif.cache_in[31:24];
          end
        endcase
      end
      cif.cache_out <= cache_read(cif.cache_select, cif.cache_width);
    end
  end

  int          lat;
  int          nw;
  logic [5:0]  sel;
  logic [31:0] d;
  logic        f;
  logic [4:0]  r;

  // Issue one request, observe cache activity and response timing, then accept the response.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    pif.req_valid = 1'b1; pif.req_write = w; pif.req_funct3 = f3;
    pif.req_addr = a; pif.req_wdata = wd; pif.req_rd = rd;
    @(negedge clk);
    pif.req_valid = 1'b0;
    lat = -1; nw = 0; sel = 6'd0; d = 32'd0; f = 1'b0; r = 5'd0;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (cif.cache_mode === 1'b0) nw++;
      sel = sel | cif.cache_select;
      if (pif.resp_valid === 1'b1) begin
        lat = c; d = pif.resp_data; f = pif.resp_fault; r = pif.resp_rd;
      end
    end
    if (lat >= 0) begin
      pif.resp_ready = 1'b1;
      @(negedge clk);
      pif.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pif.req_valid = 1'b0; pif.req_write = 1'b0; pif.req_funct3 = 3'b000;
    pif.req_addr = 32'd0; pif.req_wdata = 32'd0; pif.req_rd = 5'd0; pif.resp_ready = 1'b0;
    #12;
    total++; if (pif.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", pif.req_ready); end
    total++; if (pif.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", pif.resp_valid); end
    total++; if (pif.resp_data !== 32'd0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", pif.resp_data); end
    total++; if (pif.resp_rd !== 5'd0) begin bad++; $display("FAIL rst_resp_rd: got %0d want 0", pif.resp_rd); end
    total++; if (pif.resp_fault !== 1'b0) begin bad++; $display("FAIL rst_resp_fault: got %b want 0", pif.resp_fault); end
    total++; if (cif.cache_mode !== 1'b1) begin bad++; $display("FAIL rst_cache_mode: got %b want 1", cif.cache_mode); end
    total++; if (cif.cache_width !== 3'b010) begin bad++; $display("FAIL rst_cache_width: got %b want 010", cif.cache_width); end
    total++; if (cif.cache_select !== 6'd0) begin bad++; $display("FAIL rst_cache_select: got %h want 0", cif.cache_select); end
    total++; if (cif.cache_in !== 32'd0) begin bad++; $display("FAIL rst_cache_in: got %h want 0", cif.cache_in); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    run_req(1'b1, 3'b010, 32'h00, 32'h0a0a0a0a, 5'd1);
    total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency: got %0d want 3", lat); end
    total++; if (nw !== 1) begin bad++; $display("FAIL sw_write_cycles: got %0d want 1", nw); end
    total++; if (d !== 32'd0) begin bad++; $display("FAIL sw_data: got %h want 0", d); end
    total++; if (r !== 5'd1) begin bad++; $display("FAIL sw_rd: got %0d want 1", r); end
    run_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd2);
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", lat); end
    total++; if (nw !== 0) begin bad++; $display("FAIL lw_write_cycles: got %0d want 0", nw); end
    total++; if (d !== 32'h0a0a0a0a) begin bad++; $display("FAIL lw_data: got %h want 0a0a0a0a", d); end
    total++; if (r !== 5'd2) begin bad++; $display("FAIL lw_rd: got %0d want 2", r); end
  endtask

  task automatic test_half();
    run_req(1'b1, 3'b001, 32'h00, 32'h00000b0b, 5'd3);
    total++; if (nw !== 1) begin bad++; $display("FAIL sh_write_cycles: got %0d want 1", nw); end
    run_req(1'b0, 3'b101, 32'h00, 32'h0, 5'd4);
    total++; if (d !== 32'h00000b0b) begin bad++; $display("FAIL lhu_data: got %h want 00000b0b", d); end
    run_req(1'b0, 3'b100, 32'h00, 32'h0, 5'd5);
    total++; if (d !== 32'h0000000b) begin bad++; $display("FAIL lbu_data: got %h want 0000000b", d); end
    run_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd6);
    total++; if (d !== 32'h0a0a0b0b) begin bad++; $display("FAIL lw_after_sh: got %h want 0a0a0b0b", d); end
  endtask

  task automatic test_fault();
    run_req(1'b0, 3'b010, 32'h02, 32'h0, 5'd7);
    total++; if (lat !== (FC ? 1 : 3)) begin bad++; $display("FAIL mis_lw_latency: got %0d want %0d", lat, FC ? 1 : 3); end
    total++; if (f !== FC) begin bad++; $display("FAIL mis_lw_fault: got %b want %b", f, FC); end
    total++; if (d !== (FC ? 32'd0 : 32'h00000a0a)) begin bad++; $display("FAIL mis_lw_data: got %h want %h", d, FC ? 32'd0 : 32'h00000a0a); end
    total++; if (nw !== 0) begin bad++; $display("FAIL mis_lw_write_cycles: got %0d want 0", nw); end
    total++; if (sel !== (FC ? 6'd0 : 6'd2)) begin bad++; $display("FAIL mis_lw_select: got %h want %h", sel, FC ? 6'd0 : 6'd2); end
    total++; if (r !== 5'd7) begin bad++; $display("FAIL mis_lw_rd: got %0d want 7", r); end
    run_req(1'b0, 3'b000, 32'h40, 32'h0, 5'd8);
    total++; if (f !== FC) begin bad++; $display("FAIL range_lb_fault: got %b want %b", f, FC); end
    total++; if (lat !== (FC ? 1 : 3)) begin bad++; $display("FAIL range_lb_latency: got %0d want %0d", lat, FC ? 1 : 3); end
    total++; if (d !== (FC ? 32'd0 : 32'h0000000b)) begin bad++; $display("FAIL range_lb_data: got %h want %h", d, FC ? 32'd0 : 32'h0000000b); end
    run_req(1'b1, 3'b100, 32'h08, 32'h00000055, 5'd11);
    total++; if (f !== FC) begin bad++; $display("FAIL st100_fault: got %b want %b", f, FC); end
    total++; if (nw !== (FC ? 0 : 1)) begin bad++; $display("FAIL st100_write_cycles: got %0d want %0d", nw, FC ? 0 : 1); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    pif.req_valid = 1'b1; pif.req_write = 1'b0; pif.req_funct3 = 3'b010;
    pif.req_addr = 32'h00; pif.req_rd = 5'd9;
    @(negedge clk);
    pif.req_funct3 = 3'b100; pif.req_addr = 32'h01; pif.req_rd = 5'd10;
    for (int c = 0; c < 8 && pif.resp_valid !== 1'b1; c++) @(negedge clk);
    total++; if (pif.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_timeout: got %b want 1", pif.resp_valid); end
    for (int c = 0; c < 5; c++) begin
      total++; if (pif.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", pif.resp_valid); end
      total++; if (pif.resp_data !== 32'h0a0a0b0b) begin bad++; $display("FAIL bp_hold_data: got %h want 0a0a0b0b", pif.resp_data); end
      total++; if (pif.resp_rd !== 5'd9) begin bad++; $display("FAIL bp_hold_rd: got %0d want 9", pif.resp_rd); end
      total++; if (pif.req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready: got %b want 0", pif.req_ready); end
      @(negedge clk);
    end
    pif.resp_ready = 1'b1;
    @(negedge clk);
    pif.resp_ready = 1'b0;
    total++; if (pif.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", pif.resp_valid); end
    total++; if (pif.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", pif.req_ready); end
    @(negedge clk);
    pif.req_valid = 1'b0;
    total++; if (pif.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept: got %b want 0", pif.req_ready); end
    for (int c = 0; c < 8 && pif.resp_valid !== 1'b1; c++) @(negedge clk);
    total++; if (pif.resp_data !== 32'h0000000b) begin bad++; $display("FAIL b2b_data: got %h want 0000000b", pif.resp_data); end
    total++; if (pif.resp_rd !== 5'd10) begin bad++; $display("FAIL b2b_rd: got %0d want 10", pif.resp_rd); end
    pif.resp_ready = 1'b1;
    @(negedge clk);
    pif.resp_ready = 1'b0;
  endtask

  task automatic test_sign();
    run_req(1'b1, 3'b000, 32'h03, 32'hffffff80, 5'd12);
    run_req(1'b0, 3'b000, 32'h03, 32'h0, 5'd13);
    total++; if (d !== 32'hffffff80) begin bad++; $display("FAIL lb_sign: got %h want ffffff80", d); end
    run_req(1'b0, 3'b001, 32'h02, 32'h0, 5'd14);
    total++; if (d !== 32'hffff800a) begin bad++; $display("FAIL lh_sign: got %h want ffff800a", d); end
    run_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd15);
    total++; if (d !== 32'h800a0b0b) begin bad++; $display("FAIL lw_after_sb: got %h want 800a0b0b", d); end
  endtask

  task automatic test_reset_abort();
    run_req(1'b1, 3'b010, 32'h04, 32'h12345678, 5'd16);
    @(negedge clk);
    pif.req_valid = 1'b1; pif.req_write = 1'b1; pif.req_funct3 = 3'b010;
    pif.req_addr = 32'h04; pif.req_wdata = 32'hffffffff; pif.req_rd = 5'd17;
    @(posedge clk);
    #2;
    total++; if (cif.cache_mode !== 1'b0) begin bad++; $display("FAIL abort_issue_mode: got %b want 0", cif.cache_mode); end
    rst_n = 1'b0;
    #1;
    total++; if (cif.cache_mode !== 1'b1) begin bad++; $display("FAIL abort_mode: got %b want 1", cif.cache_mode); end
    total++; if (cif.cache_select !== 6'd0) begin bad++; $display("FAIL abort_select: got %h want 0", cif.cache_select); end
    total++; if (cif.cache_in !== 32'd0) begin bad++; $display("FAIL abort_in: got %h want 0", cif.cache_in); end
    total++; if (pif.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", pif.req_ready); end
    pif.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (pif.resp_valid !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b want 0", pif.resp_valid); end
    run_req(1'b0, 3'b010, 32'h04, 32'h0, 5'd18);
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL abort_preserved: got %h want 12345678", d); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_word();
    test_half();
    test_fault();
    test_backpressure();
    test_sign();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
